fifo_stream_checker: RTL and testbench
======================================

Name: fifo_stream_checker

Overview:
- Synthesizable, parametrised checker for a synchronous FIFO.
- Sits beside the FIFO DUT, snoops its stimulus (wr_en, rd_en, data_in), and runs an internal cycle-accurate reference model of the FIFO.
- Compares every DUT output against the model each clock and keeps saturating error/correct counters plus a first-error capture record.
- Provides a finish/done handshake so a bench or on-chip BIST can read the pass/fail result.

Parameters:
- DATA_WIDTH, 16, width of data_in / data_out.
- DEPTH, 8, FIFO entries; power of two, at least 4.
- CNT_WIDTH, 32, width of the error, correct and cycle counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- check_en  in  1  1 = compare outputs and update counters this cycle.
- wr_en  in  1  DUT write request (snooped).
- rd_en  in  1  DUT read request (snooped).
- data_in  in  DATA_WIDTH  DUT write data (snooped).
- dut_data_out  in  DATA_WIDTH  DUT read data.
- dut_wr_ack, dut_overflow, dut_underflow  in  1 each  DUT registered status outputs.
- dut_full, dut_empty, dut_almostfull, dut_almostempty  in  1 each  DUT combinational flags.
- finish_req  in  1  single-cycle pulse requesting the end of checking.
- done  out  1  result valid; sticky until rst.
- pass  out  1  valid while done; 1 iff err_count == 0.
- err_count  out  CNT_WIDTH  number of mismatching cycles.
- ok_count  out  CNT_WIDTH  number of fully matching checked cycles.
- first_err_valid  out  1  a first error has been captured.
- first_err_cycle  out  CNT_WIDTH  cycle index of the first error.
- first_err_mask  out  8  fields that mismatched on the first error.
  - Bit order: {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty} = bits [7:0].

Behaviour:
- Reset (rst=1 at a clock edge), checked at the next edge:
  - Model: count=0, pointers=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Outputs: done=0, pass=0, err_count=0, ok_count=0, first_err_valid=0, first_err_cycle=0, first_err_mask=0.
  - Internal cycle counter=0.
  - Reset asserted mid-operation discards all history; no compare happens in a reset cycle.
- Model memory and pointers:
  - DEPTH x DATA_WIDTH storage.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is log2(DEPTH)+1 bits.
- Model write:
  - wr_en and count < DEPTH: store data_in, wr_ptr++, wr_ack=1 at the next edge.
  - wr_en and full: overflow=1, wr_ack=0.
  - No wr_en: wr_ack=0, overflow=0.
- Model read:
  - rd_en and count > 0: data_out <= mem[rd_ptr], rd_ptr++.
  - rd_en and empty: underflow=1.
  - No successful read: data_out holds its value; underflow=0 unless set by an empty read.
- Simultaneous wr_en and rd_en:
  - Empty: write only, underflow=1.
  - Full: read only, overflow=1.
  - Otherwise: both occur and count is unchanged.
- Model flags, combinational from count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almostfull = (count == DEPTH-1)
  - almostempty = (count == 1)
- Compare:
  - Combinational XOR of the 8 fields into a mismatch vector, evaluated each cycle with check_en=1, rst=0, done=0.
  - Any bit set: err_count++ at the next edge.
  - No bit set: ok_count++ at the next edge.
  - Latency: a mismatch in cycle N is visible on err_count in cycle N+1.
- First error: on the first mismatch, first_err_cycle and first_err_mask capture that cycle's values and first_err_valid=1. Later errors do not overwrite the record.
- Counters:
  - Both counters saturate at all-ones.
  - The cycle counter increments every non-reset cycle, irrespective of check_en, and also saturates.
- check_en=0: the model still tracks stimulus; counters and capture are frozen.
- Finish:
  - finish_req seen at an edge: done=1 and pass=(err_count==0 after any update in that same cycle) from the next cycle.
  - From then on, counters and capture freeze and the model keeps running.
  - finish_req while done=1 is ignored.

Optional Feature:
- Macro: FIFO_CHK_ALMOST_EN.
- Defined: almostfull and almostempty are compared as described above.
- Undefined:
  - Mismatch bits [1:0] are forced to 0.
  - first_err_mask[1:0] always reads 0.
  - dut_almostfull and dut_almostempty are ignored.

Test Plan:
- Fill then drain, DEPTH=8, ideal DUT:
  - Write 0x0001..0x0008, then 8 reads.
  - Expected: err_count=0, ok_count = checked cycles, pass=1 after finish_req.
- Overflow: 9 writes into an empty FIFO, DUT asserts dut_overflow on the 9th.
  - Expected: no error, model overflow=1 in the cycle after the 9th write.
- Injected data fault: DUT returns 0x00FF instead of 0x0003 on the 3rd read (cycle 14).
  - Expected: err_count=1, first_err_cycle=14, first_err_mask=8'h80, pass=0.
- Simultaneous read and write:
  - At count=0: only the write takes effect, underflow=1.
  - At count=8: only the read takes effect, overflow=1.
  - At count=4: count stays 4.
  - Any DUT deviation in these cases increments err_count.
- Reset mid-run: reset with err_count=3 and count=5.
  - Expected: all outputs read 0 the next cycle, and the model reports empty=1.
- Saturation with CNT_WIDTH=4: 20 consecutive mismatches.
  - Expected: err_count holds at 15.
  - finish_req then gives done=1, pass=0, and counters stay frozen afterwards.

Source files
------------

// File: rtl/fifo_stream_checker.sv
// ---------------------------------------------------------------------------
// fifo_stream_checker
//
// Purpose:
//   Watches the stimulus going into a synchronous FIFO (wr_en, rd_en, data_in).
//   It runs its own cycle-accurate reference FIFO on that stimulus and compares
//   every DUT output with the reference on every clock. The results are kept in
//   saturating error/correct counters and in a record of the first error. A
//   finish/done handshake hands the pass/fail verdict to a bench or on-chip BIST.
//
// Optional feature:
//   FIFO_CHK_ALMOST_EN  defined   -> almostfull / almostempty are compared.
//                       undefined -> mismatch bits [1:0] are forced to 0, and
//                                    dut_almostfull / dut_almostempty are ignored.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   check_en            1 = compare this cycle and update the counters
//   wr_en, rd_en        snooped DUT requests
//   data_in             snooped DUT write data
//   dut_data_out        DUT read data (registered)
//   dut_wr_ack, dut_overflow, dut_underflow
//                       DUT registered status outputs
//   dut_full, dut_empty, dut_almostfull, dut_almostempty
//                       DUT combinational flags
//   finish_req          single-cycle pulse that ends checking
//   done, pass          verdict; done is sticky until rst, pass is valid while done
//   err_count           number of mismatching checked cycles (saturating)
//   ok_count            number of fully matching checked cycles (saturating)
//   first_err_valid/cycle/mask
//                       record of the first mismatch; mask bit order is
//                       {data_out, wr_ack, overflow, underflow,
//                        full, empty, almostfull, almostempty}
//
// Handshake:
//   finish_req is sampled at a rising edge while done=0. From the next cycle,
//   done=1 and pass holds the verdict, which includes any counter update made
//   in the finish_req cycle. A finish_req that arrives while done=1 has no
//   effect. The state of the check phase can be read directly from done.
// ---------------------------------------------------------------------------
module fifo_stream_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  check_en,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] dut_data_out,
  input  logic                  dut_wr_ack,
  input  logic                  dut_overflow,
  input  logic                  dut_underflow,
  input  logic                  dut_full,
  input  logic                  dut_empty,
  input  logic                  dut_almostfull,
  input  logic                  dut_almostempty,
  input  logic                  finish_req,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  ok_count,
  output logic                  first_err_valid,
  output logic [CNT_WIDTH-1:0]  first_err_cycle,
  output logic [7:0]            first_err_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // -------------------------------------------------------------------------
  // Check-phase FSM: CHECK until finish_req, then DONE until reset.
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_CHECK = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CHECK: if (finish_req) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_CHECK;
    endcase
  end

  logic pass_q, pass_d;

  always_comb begin
    done = (state_q == ST_DONE);
    pass = pass_q;
  end

  // -------------------------------------------------------------------------
  // Reference FIFO model
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_m, empty_m, afull_m, aempty_m;
  logic do_wr, do_rd;

  always_comb begin
    full_m   = (count_q == DEPTH_C);
    empty_m  = (count_q == '0);
    afull_m  = (count_q == DEPTH_C - CW'(1));
    aempty_m = (count_q == CW'(1));

    // A full FIFO can still accept a read, and an empty FIFO can still accept
    // a write. So simultaneous requests at either limit reduce to a single op.
    do_wr = wr_en & ~full_m;
    do_rd = rd_en & ~empty_m;

    mem_d = mem_q;
    if (do_wr) mem_d[wr_ptr_q] = data_in;

    wr_ptr_d    = wr_ptr_q + PW'(do_wr);
    rd_ptr_d    = rd_ptr_q + PW'(do_rd);
    count_d     = count_q + CW'(do_wr) - CW'(do_rd);
    data_out_d  = do_rd ? mem_q[rd_ptr_q] : data_out_q;
    wr_ack_d    = do_wr;
    overflow_d  = wr_en & full_m;
    underflow_d = rd_en & empty_m;
  end

  // Storage contents need no reset; the pointers and count make them valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Compare
  // -------------------------------------------------------------------------
  logic [1:0] mm_almost;
  logic [7:0] mismatch;

`ifdef FIFO_CHK_ALMOST_EN
  assign mm_almost = {dut_almostfull ^ afull_m, dut_almostempty ^ aempty_m};
`else
  assign mm_almost = 2'b00;
  logic almost_unused;
  assign almost_unused = ^{dut_almostfull, dut_almostempty, afull_m, aempty_m};
`endif

  assign mismatch = {
    (dut_data_out != data_out_q),
    dut_wr_ack    ^ wr_ack_q,
    dut_overflow  ^ overflow_q,
    dut_underflow ^ underflow_q,
    dut_full      ^ full_m,
    dut_empty     ^ empty_m,
    mm_almost
  };

  // -------------------------------------------------------------------------
  // Counters and first-error capture
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic [CNT_WIDTH-1:0] ok_q, ok_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic                 fev_q, fev_d;
  logic [CNT_WIDTH-1:0] fec_q, fec_d;
  logic [7:0]           fem_q, fem_d;
  logic                 cmp_en, any_mm;

  always_comb begin
    // Reset cycles never reach here: the sequential blocks take the reset branch.
    cmp_en = check_en & (state_q == ST_CHECK);
    any_mm = |mismatch;

    err_d = err_q;
    ok_d  = ok_q;
    fev_d = fev_q;
    fec_d = fec_q;
    fem_d = fem_q;

    if (cmp_en) begin
      if (any_mm) begin
        if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
        if (!fev_q) begin
          fev_d = 1'b1;
          fec_d = cyc_q;
          fem_d = mismatch;
        end
      end else if (ok_q != '1) begin
        ok_d = ok_q + CNT_WIDTH'(1);
      end
    end

    cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_WIDTH'(1);

    // The verdict includes the update made in the finish_req cycle itself.
    pass_d = pass_q;
    if ((state_q == ST_CHECK) && finish_req) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      ok_q   <= '0;
      cyc_q  <= '0;
      fev_q  <= 1'b0;
      fec_q  <= '0;
      fem_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      ok_q   <= ok_d;
      cyc_q  <= cyc_d;
      fev_q  <= fev_d;
      fec_q  <= fec_d;
      fem_q  <= fem_d;
      pass_q <= pass_d;
    end
  end

  assign err_count       = err_q;
  assign ok_count        = ok_q;
  assign first_err_valid = fev_q;
  assign first_err_cycle = fec_q;
  assign first_err_mask  = fem_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_checker
//
// An ideal queue-based FIFO stands in for the DUT. Its outputs can be
// corrupted on chosen cycles: flt_data XORs the read data, and flt_stat[6:0]
// flips wr_ack..almostempty. Two checkers watch the same traffic. u_dut uses
// the default counter width; u_sat uses 4-bit counters so that saturation can
// be exercised.
// ---------------------------------------------------------------------------
module tb_fifo_stream_checker;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int SCW   = 4;
  localparam int SBW   = 2 * CW + 2;
  localparam int SSBW  = 2 * SCW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          check_en = 1'b0, check_en_s = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          finish_req = 1'b0, finish_s = 1'b0;
  logic [DW-1:0] flt_data = '0;
  logic [6:0]    flt_stat = '0;

  // ---------------- ideal FIFO standing in for the DUT ----------------
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] ref_dout;
  logic          ref_ack, ref_ov, ref_un;
  int            ref_cnt;
  bit            can_rd, can_wr;

  always @(posedge clk) begin
    if (rst) begin
      ref_q.delete();
      ref_dout <= '0;
      ref_ack  <= 1'b0;
      ref_ov   <= 1'b0;
      ref_un   <= 1'b0;
      ref_cnt  <= 0;
    end else begin
      can_rd = (ref_q.size() > 0);
      can_wr = (ref_q.size() < DEPTH);
      ref_ack <= wr_en && can_wr;
      ref_ov  <= wr_en && !can_wr;
      ref_un  <= rd_en && !can_rd;
      if (rd_en && can_rd) ref_dout <= ref_q.pop_front();
      if (wr_en && can_wr) ref_q.push_back(data_in);
      ref_cnt <= ref_q.size();
    end
  end

  logic [DW-1:0] dut_data_out;
  logic dut_wr_ack, dut_overflow, dut_underflow;
  logic dut_full, dut_empty, dut_almostfull, dut_almostempty;

  assign dut_data_out    = ref_dout ^ flt_data;
  assign dut_wr_ack      = ref_ack ^ flt_stat[6];
  assign dut_overflow    = ref_ov ^ flt_stat[5];
  assign dut_underflow   = ref_un ^ flt_stat[4];
  assign dut_full        = (ref_cnt == DEPTH) ^ flt_stat[3];
  assign dut_empty       = (ref_cnt == 0) ^ flt_stat[2];
  assign dut_almostfull  = (ref_cnt == DEPTH - 1) ^ flt_stat[1];
  assign dut_almostempty = (ref_cnt == 1) ^ flt_stat[0];

  // ---------------- checkers ----------------
  logic           done, pass, fev;
  logic [CW-1:0]  err_count, ok_count, fec;
  logic [7:0]     fem;
  logic           done_s, pass_s, fev_s;
  logic [SCW-1:0] err_s, ok_s, fec_s;
  logic [7:0]     fem_s;

  fifo_stream_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .check_en(check_en),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .dut_data_out(dut_data_out), .dut_wr_ack(dut_wr_ack),
    .dut_overflow(dut_overflow), .dut_underflow(dut_underflow),
    .dut_full(dut_full), .dut_empty(dut_empty),
    .dut_almostfull(dut_almostfull), .dut_almostempty(dut_almostempty),
    .finish_req(finish_req), .done(done), .pass(pass),
    .err_count(err_count), .ok_count(ok_count),
    .first_err_valid(fev), .first_err_cycle(fec), .first_err_mask(fem)
  );

  fifo_stream_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(SCW)) u_sat (
    .clk(clk), .rst(rst), .check_en(check_en_s),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .dut_data_out(dut_data_out), .dut_wr_ack(dut_wr_ack),
    .dut_overflow(dut_overflow), .dut_underflow(dut_underflow),
    .dut_full(dut_full), .dut_empty(dut_empty),
    .dut_almostfull(dut_almostfull), .dut_almostempty(dut_almostempty),
    .finish_req(finish_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .ok_count(ok_s),
    .first_err_valid(fev_s), .first_err_cycle(fec_s), .first_err_mask(fem_s)
  );

  // ---------------- scoreboard ----------------
  logic [SBW-1:0]  exp_q[$];
  logic [SSBW-1:0] exp_s_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0]  exp_err, exp_ok, exp_cyc, exp_fec;
  logic           exp_done, exp_pass, exp_fev;
  logic [7:0]     exp_fem;
  logic [SCW-1:0] exp_s_err, exp_s_ok;
  logic           exp_s_done, exp_s_pass;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    finish_req = 1'b0; finish_s = 1'b0; flt_data = '0; flt_stat = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_err = '0; exp_ok = '0; exp_cyc = '0; exp_fec = '0;
    exp_done = 1'b0; exp_pass = 1'b0; exp_fev = 1'b0; exp_fem = '0;
    exp_s_err = '0; exp_s_ok = '0; exp_s_done = 1'b0; exp_s_pass = 1'b0;
    exp_q.delete();
    exp_s_q.delete();
  endtask

  // Drives one cycle, predicts both checkers, then pops and compares after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic [DW-1:0] fd, input logic [6:0] fs,
                       input logic fin, input logic fin_s);
    logic [7:0]      m;
    logic [SBW-1:0]  exp_v, got_v;
    logic [SSBW-1:0] exp_sv, got_sv;
    wr_en = w; rd_en = r; data_in = d; flt_data = fd; flt_stat = fs;
    finish_req = fin; finish_s = fin_s;
    m = {|fd, fs};
`ifndef FIFO_CHK_ALMOST_EN
    m[1:0] = 2'b00;
`endif
    if (check_en && !exp_done) begin
      if (m != 8'h00) begin
        if (exp_err != '1) exp_err = exp_err + 1;
        if (!exp_fev) begin exp_fev = 1'b1; exp_fec = exp_cyc; exp_fem = m; end
      end else if (exp_ok != '1) begin
        exp_ok = exp_ok + 1;
      end
    end
    if (fin && !exp_done) begin exp_done = 1'b1; exp_pass = (exp_err == '0); end
    if (exp_cyc != '1) exp_cyc = exp_cyc + 1;
    exp_q.push_back({exp_done, exp_pass, exp_err, exp_ok});

    if (check_en_s && !exp_s_done) begin
      if (m != 8'h00) begin
        if (exp_s_err != '1) exp_s_err = exp_s_err + 1;
      end else if (exp_s_ok != '1) begin
        exp_s_ok = exp_s_ok + 1;
      end
    end
    if (fin_s && !exp_s_done) begin exp_s_done = 1'b1; exp_s_pass = (exp_s_err == '0); end
    exp_s_q.push_back({exp_s_done, exp_s_pass, exp_s_err, exp_s_ok});

    @(posedge clk); @(negedge clk);
    finish_req = 1'b0; finish_s = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {done, pass, err_count, ok_count};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL main_counters t=%0t got done/pass/err/ok=%0b/%0b/%0d/%0d exp=%0b/%0b/%0d/%0d",
               $time, got_v[SBW-1], got_v[SBW-2], got_v[2*CW-1:CW], got_v[CW-1:0],
               exp_v[SBW-1], exp_v[SBW-2], exp_v[2*CW-1:CW], exp_v[CW-1:0]);
    end
    exp_sv = exp_s_q.pop_front();
    got_sv = {done_s, pass_s, err_s, ok_s};
    n_tests++;
    if (got_sv !== exp_sv) begin
      n_fail++;
      $display("FAIL sat_counters t=%0t got done/pass/err/ok=%0b/%0b/%0d/%0d exp=%0b/%0b/%0d/%0d",
               $time, got_sv[SSBW-1], got_sv[SSBW-2], got_sv[2*SCW-1:SCW], got_sv[SCW-1:0],
               exp_sv[SSBW-1], exp_sv[SSBW-2], exp_sv[2*SCW-1:SCW], exp_sv[SCW-1:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({done, pass, err_count, ok_count, fev, fec, fem} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got done=%0b pass=%0b err=%0d ok=%0d fev=%0b fec=%0d fem=%h exp all 0",
               done, pass, err_count, ok_count, fev, fec, fem);
    end
    n_tests++;
    if ({done_s, pass_s, err_s, ok_s, fev_s, fec_s, fem_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_sat got done=%0b err=%0d ok=%0d exp all 0", done_s, err_s, ok_s);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    check_en = 1'b1;
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'($urandom_range(0, 65535)), '0, '0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== '0 || ok_count !== CW'(19)) begin
      n_fail++;
      $display("FAIL fill_drain got done=%0b pass=%0b err=%0d ok=%0d exp 1/1/0/19", done, pass, err_count, ok_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    check_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, DW'($urandom_range(0, 65535)), '0, '0, 1'b0, 1'b0);
    idle(2);
    n_tests++;
    if (err_count !== '0 || fev !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow got err=%0d fev=%0b exp 0/0", err_count, fev);
    end
  endtask

  task automatic test_data_fault();
    do_reset();
    check_en = 1'b1;
    idle(3);
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 16'h00FC, '0, 1'b0, 1'b0);  // 0x0003 seen as 0x00FF
    cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    // Faults and a second finish_req after done must change nothing.
    cycle(1'b0, 1'b1, '0, 16'h0001, 7'b0000100, 1'b1, 1'b0);
    n_tests++;
    if (fev !== 1'b1 || fec !== CW'(14) || fem !== 8'h80) begin
      n_fail++;
      $display("FAIL first_err got valid=%0b cycle=%0d mask=%h exp 1/14/80", fev, fec, fem);
    end
    n_tests++;
    if (err_count !== CW'(1) || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL data_fault_verdict got err=%0d pass=%0b done=%0b exp 1/0/1", err_count, pass, done);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    check_en = 1'b1;
    cycle(1'b1, 1'b1, 16'hA000, '0, '0, 1'b0, 1'b0);             // count 0: write only
    idle(1);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(16'hA000 + i), '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, '0, '0, 1'b0, 1'b0);             // count 8: read only
    idle(1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hC0DE, '0, '0, 1'b0, 1'b0);             // count 4: stays 4
    idle(1);
    n_tests++;
    if (err_count !== '0) begin
      n_fail++;
      $display("FAIL simultaneous_ideal got err=%0d exp 0", err_count);
    end
    cycle(1'b0, 1'b0, '0, '0, 7'b0010000, 1'b0, 1'b0);           // wrong underflow
    cycle(1'b0, 1'b0, '0, '0, 7'b1000000, 1'b0, 1'b0);           // wrong wr_ack
    n_tests++;
    if (err_count !== CW'(2) || fem !== 8'h10) begin
      n_fail++;
      $display("FAIL simultaneous_deviation got err=%0d mask=%h exp 2/10", err_count, fem);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_midrun();
    do_reset();
    check_en = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'($urandom_range(0, 65535)), '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, 7'b0000100, 1'b0, 1'b0);
    n_tests++;
    if (err_count !== CW'(3) || fem !== 8'h04) begin
      n_fail++;
      $display("FAIL midrun_setup got err=%0d mask=%h exp 3/04", err_count, fem);
    end
    do_reset();
    n_tests++;
    if ({done, pass, err_count, ok_count, fev, fec, fem} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset got err=%0d ok=%0d fev=%0b fec=%0d fem=%h exp all 0",
               err_count, ok_count, fev, fec, fem);
    end
    idle(2);  // ideal DUT now reports empty; the model must agree
    n_tests++;
    if (err_count !== '0 || ok_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL midrun_empty got err=%0d ok=%0d exp 0/2", err_count, ok_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    check_en   = 1'b0;  // main checker frozen while faults fly
    check_en_s = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, '0, 7'b0000100, 1'b0, 1'b0);
    n_tests++;
    if (err_s !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_err got %0d exp 15", err_s);
    end
    cycle(1'b0, 1'b0, '0, '0, 7'b0000100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    n_tests++;
    if (done_s !== 1'b1 || pass_s !== 1'b0 || err_s !== 4'hF || ok_s !== 4'h0
        || fem_s !== 8'h04 || fec_s !== 4'h0) begin
      n_fail++;
      $display("FAIL sat_finish got done=%0b pass=%0b err=%0d ok=%0d mask=%h cyc=%0d exp 1/0/15/0/04/0",
               done_s, pass_s, err_s, ok_s, fem_s, fec_s);
    end
    n_tests++;
    if (err_count !== '0 || ok_count !== '0 || fev !== 1'b0) begin
      n_fail++;
      $display("FAIL check_en_freeze got err=%0d ok=%0d fev=%0b exp 0/0/0", err_count, ok_count, fev);
    end
    check_en_s = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_data_fault();
    test_simultaneous();
    test_reset_midrun();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
